// File: rtl/tone_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tone_scheduler
// Purpose : One-piezo sound sequencer: power-up intro, then prioritised
//           correct/wrong/game-over jingles. Optional MUTE_SWITCH_EN adds mute.
// Revision: 1.0 - initial release
// ============================================================================
module tone_scheduler #(
    parameter int NOTE_CYC = 5_000_000,
    parameter int GAP_CYC  = 500_000,
    parameter int SIM_DIV  = 0
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       correct_hit,
    input  logic       wrong_hit,
    input  logic       game_over_hit,
`ifdef MUTE_SWITCH_EN
    input  logic       mute,
`endif
    output logic       speaker,
    output logic       fi_done,
    output logic       busy,
    output logic [2:0] sound_id
);

    function automatic logic [16:0] half_cyc(input int raw);
        int v;
        v = raw >> SIM_DIV;
        if (v < 1) v = 1;
        return 17'(v);
    endfunction

    function automatic logic [2:0] highest(input logic [2:0] v);
        if (v[2])      return 3'd3;
        else if (v[1]) return 3'd2;
        else if (v[0]) return 3'd1;
        else           return 3'd0;
    endfunction

    localparam logic [16:0] C_H_C5  = half_cyc(47801);
    localparam logic [16:0] C_H_E5  = half_cyc(37936);
    localparam logic [16:0] C_H_G5  = half_cyc(31888);
    localparam logic [16:0] C_H_C6  = half_cyc(23878);
    localparam logic [16:0] C_H_E6  = half_cyc(18953);
    localparam logic [16:0] C_H_LOW = half_cyc(125000);

    localparam int C_CNT_MAX = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
    localparam int CNT_W     = $clog2(C_CNT_MAX + 1);
    localparam logic [CNT_W-1:0] C_NOTE_LAST = CNT_W'(NOTE_CYC - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] C_SND_NONE    = 3'd0;
    localparam logic [2:0] C_SND_CORRECT = 3'd1;
    localparam logic [2:0] C_SND_WRONG   = 3'd2;
    localparam logic [2:0] C_SND_OVER    = 3'd3;
    localparam logic [2:0] C_SND_INTRO   = 3'd4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_INTRO = 2'd2,
        ST_PLAY  = 2'd3
    } state_t;

    state_t           r_state;
    logic [2:0]       r_sound_id;
    logic [1:0]       r_note_idx;
    logic             r_gap;
    logic [CNT_W-1:0] r_cnt;
    logic [16:0]      r_tcnt;
    logic             r_speaker;
    logic             r_fi_done;
    logic [2:0]       r_pend;       // {over, wrong, correct}

    state_t           w_nxt_state;
    logic [2:0]       w_nxt_sound;
    logic [1:0]       w_nxt_note;
    logic             w_nxt_gap;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [16:0]      w_nxt_tcnt;
    logic             w_nxt_spk;
    logic             w_nxt_fi;
    logic [2:0]       w_nxt_pend;

    logic [2:0]       w_req;
    logic [2:0]       w_pool;
    logic             w_start;
    logic [2:0]       w_start_id;
    logic             w_done;
    logic             w_last_note;
    logic [16:0]      w_half;

    assign w_req = {game_over_hit, wrong_hit, correct_hit};

    always_comb begin
        w_half = C_H_C5;
        unique case (r_sound_id)
            C_SND_INTRO: begin
                unique case (r_note_idx)
                    2'd0:    w_half = C_H_C5;
                    2'd1:    w_half = C_H_E5;
                    2'd2:    w_half = C_H_G5;
                    default: w_half = C_H_C6;
                endcase
            end
            C_SND_CORRECT: w_half = r_note_idx[0] ? C_H_E6 : C_H_C6;
            C_SND_WRONG:   w_half = C_H_LOW;
            C_SND_OVER: begin
                unique case (r_note_idx)
                    2'd0:    w_half = C_H_G5;
                    2'd1:    w_half = C_H_E5;
                    default: w_half = C_H_C5;
                endcase
            end
            default: w_half = C_H_C5;
        endcase
    end

    assign w_last_note = (r_sound_id == C_SND_INTRO || r_sound_id == C_SND_OVER)
                         ? (r_note_idx == 2'd3) : (r_note_idx == 2'd1);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_sound = r_sound_id;
        w_nxt_note  = r_note_idx;
        w_nxt_gap   = r_gap;
        w_nxt_cnt   = r_cnt;
        w_nxt_tcnt  = r_tcnt;
        w_nxt_spk   = r_speaker;
        w_nxt_fi    = r_fi_done;
        w_nxt_pend  = r_pend;
        w_pool      = r_pend;
        w_start     = 1'b0;
        w_start_id  = C_SND_NONE;
        w_done      = 1'b0;

        // Note/gap timing and square-wave generation
        if (r_state == ST_INTRO || r_state == ST_PLAY) begin
            if (!r_gap) begin
                if (r_tcnt == w_half - 17'd1) begin
                    w_nxt_spk  = ~r_speaker;
                    w_nxt_tcnt = '0;
                end else begin
                    w_nxt_tcnt = r_tcnt + 17'd1;
                end
                if (r_cnt == C_NOTE_LAST) begin
                    w_nxt_gap  = 1'b1;
                    w_nxt_cnt  = '0;
                    w_nxt_spk  = 1'b0;
                    w_nxt_tcnt = '0;
                end else begin
                    w_nxt_cnt = r_cnt + C_CNT_ONE;
                end
            end else if (r_cnt == C_GAP_LAST) begin
                if (w_last_note) begin
                    w_done = 1'b1;
                end else begin
                    w_nxt_note = r_note_idx + 2'd1;
                    w_nxt_gap  = 1'b0;
                    w_nxt_cnt  = '0;
                    w_nxt_tcnt = '0;
                    w_nxt_spk  = 1'b0;
                end
            end else begin
                w_nxt_cnt = r_cnt + C_CNT_ONE;
            end
        end

        unique case (r_state)
            ST_BOOT: begin
                w_start    = 1'b1;
                w_start_id = C_SND_INTRO;
            end
            ST_IDLE: begin
                w_pool = r_pend | w_req;
                if (|w_pool) begin
                    w_start    = 1'b1;
                    w_start_id = highest(w_pool);
                end
            end
            ST_INTRO: begin
                if (w_done) begin
                    w_nxt_fi = 1'b1;
                    if (|r_pend) begin
                        w_start    = 1'b1;
                        w_start_id = highest(r_pend);
                    end else begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_sound = C_SND_NONE;
                    end
                end
            end
            ST_PLAY: begin
                w_pool = r_pend | w_req;
                if (w_done) begin
                    if (|w_pool) begin
                        w_start    = 1'b1;
                        w_start_id = highest(w_pool);
                    end else begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_sound = C_SND_NONE;
                    end
                end else if (highest(w_req) > r_sound_id) begin
                    w_start    = 1'b1;
                    w_start_id = highest(w_req);
                end else begin
                    w_nxt_pend = w_pool;
                end
            end
            default: w_nxt_state = ST_BOOT;
        endcase

        // Any new sound restarts from note 0; the aborted/finished one is dropped
        if (w_start) begin
            w_nxt_state = (w_start_id == C_SND_INTRO) ? ST_INTRO : ST_PLAY;
            w_nxt_sound = w_start_id;
            w_nxt_note  = 2'd0;
            w_nxt_gap   = 1'b0;
            w_nxt_cnt   = '0;
            w_nxt_tcnt  = '0;
            w_nxt_spk   = 1'b0;
            w_nxt_pend  = w_pool;
            unique case (w_start_id)
                C_SND_CORRECT: w_nxt_pend[0] = 1'b0;
                C_SND_WRONG:   w_nxt_pend[1] = 1'b0;
                C_SND_OVER:    w_nxt_pend    = 3'b000;
                default:       w_nxt_pend    = w_pool;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_BOOT;
            r_sound_id <= C_SND_NONE;
            r_note_idx <= 2'd0;
            r_gap      <= 1'b0;
            r_cnt      <= '0;
            r_tcnt     <= '0;
            r_speaker  <= 1'b0;
            r_fi_done  <= 1'b0;
            r_pend     <= 3'b000;
        end else begin
            r_state    <= w_nxt_state;
            r_sound_id <= w_nxt_sound;
            r_note_idx <= w_nxt_note;
            r_gap      <= w_nxt_gap;
            r_cnt      <= w_nxt_cnt;
            r_tcnt     <= w_nxt_tcnt;
            r_speaker  <= w_nxt_spk;
            r_fi_done  <= w_nxt_fi;
            r_pend     <= w_nxt_pend;
        end
    end

`ifdef MUTE_SWITCH_EN
    assign speaker = r_speaker & ~mute;
`else
    assign speaker = r_speaker;
`endif
    assign fi_done  = r_fi_done;
    assign sound_id = r_sound_id;
    assign busy     = (r_sound_id != C_SND_NONE);

endmodule
`default_nettype wire
